// File: rtl/booth_divider.sv
// booth_divider: sequential unsigned non-restoring divider.
// Operands are loaded one at a time over in_data. The first start rising edge
// loads the dividend and the second loads the divisor. After that the block
// produces one quotient bit per clock. Results are held with done high until
// the next load.
module booth_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LD_DVS  = 3'd1,
    S_CHECK   = 3'd2,
    S_STEP    = 3'd3,
    S_CORRECT = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t state;
  state_t state_nxt;

  logic                    start_d;
  logic                    pe;
  logic signed [WIDTH:0]   a_reg;
  logic        [WIDTH-1:0] q_reg;
  logic        [WIDTH-1:0] m_reg;
  logic        [CNT_W-1:0] cnt;
  logic signed [WIDTH:0]   a_shl;
  logic signed [WIDTH:0]   a_step;
  logic signed [WIDTH:0]   a_fix;

  // Partial remainder plus divisor. The result wraps modulo 2^(WIDTH+1).
  function automatic logic signed [WIDTH:0] add_m(input logic signed [WIDTH:0] a,
                                                  input logic [WIDTH-1:0] m);
    return a + $signed({1'b0, m});
  endfunction

  // Partial remainder minus divisor. The result wraps modulo 2^(WIDTH+1).
  function automatic logic signed [WIDTH:0] sub_m(input logic signed [WIDTH:0] a,
                                                  input logic [WIDTH-1:0] m);
    return a - $signed({1'b0, m});
  endfunction

  assign pe = start & ~start_d;

  // Non-restoring iteration: shift {A,Q} left, then add or subtract M based on the old sign of A.
  always_comb begin
    a_shl  = {a_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    a_step = a_reg[WIDTH] ? add_m(a_shl, m_reg) : sub_m(a_shl, m_reg);
    a_fix  = a_reg[WIDTH] ? add_m(a_reg, m_reg) : a_reg;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and status decode.
  // A zero divisor also passes through CORRECT, which leaves the results
  // untouched in that case. This gives the zero-divisor path a fixed
  // two-cycle latency after the divisor load.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE:    if (pe) state_nxt = S_LD_DVS;
      S_LD_DVS: begin
        busy = 1'b1;
        if (pe) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        busy      = 1'b1;
        state_nxt = (m_reg == '0) ? S_CORRECT : S_STEP;
      end
      S_STEP: begin
        busy = 1'b1;
        if (cnt == CNT_W'(1)) state_nxt = S_CORRECT;
      end
      S_CORRECT: begin
        busy      = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (pe) state_nxt = S_LD_DVS;
      end
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Edge detector, operand capture, iteration datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_d     <= 1'b0;
      a_reg       <= '0;
      q_reg       <= '0;
      m_reg       <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      start_d <= start;
      case (state)
        S_IDLE: if (pe) q_reg <= in_data;
        S_LD_DVS: if (pe) m_reg <= in_data;
        S_CHECK: begin
          if (m_reg == '0) begin
            quotient    <= '1;
            remainder   <= q_reg;
            div_by_zero <= 1'b1;
          end else begin
            a_reg <= '0;
            cnt   <= CNT_INIT;
          end
        end
        S_STEP: begin
          a_reg <= a_step;
          q_reg <= {q_reg[WIDTH-2:0], ~a_step[WIDTH]};
          cnt   <= cnt - CNT_W'(1);
        end
        S_CORRECT: begin
          if (!div_by_zero) begin
            a_reg     <= a_fix;
            quotient  <= q_reg;
            remainder <= a_fix[WIDTH-1:0];
          end
        end
        S_DONE: begin
          if (pe) begin
            q_reg       <= in_data;
            div_by_zero <= 1'b0;
          end
        end
        default: begin
          quotient    <= '0;
          remainder   <= '0;
          div_by_zero <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_divider.sv
// tb_booth_divider: directed vectors with hand-computed results for booth_divider (WIDTH=8).
module tb_booth_divider;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             done;
  logic             busy;
  logic             div_by_zero;

  int total = 0;
  int bad   = 0;

  booth_divider #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_data     (in_data),
    .quotient    (quotient),
    .remainder   (remainder),
    .done        (done),
    .busy        (busy),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One clean strobe: raise start at a falling edge and drop it at the next one.
  task automatic strobe(input logic [WIDTH-1:0] v);
    @(negedge clk);
    in_data = v;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Load the divisor and wait for done. A start pulse is injected at wait
  // cycle pulse_at when pulse_at >= 0.
  task automatic finish_div(input string tag, input logic [WIDTH-1:0] dvs,
                            input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                            input logic edz, input int elat, input int pulse_at);
    int n;
    strobe(dvs);
    n = 0;
    chk({tag, "_busy_check"}, busy, 1'b1);
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
      if (pulse_at >= 0 && n == pulse_at) begin
        in_data = 8'd0;
        start   = 1'b1;
      end else if (pulse_at >= 0 && n == pulse_at + 1) begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk({tag, "_latency"}, n, elat);
    chk({tag, "_quotient"}, quotient, eq);
    chk({tag, "_remainder"}, remainder, er);
    chk({tag, "_dbz"}, div_by_zero, edz);
    chk({tag, "_busy_done"}, busy, 1'b0);
  endtask

  task automatic run_div(input string tag, input logic [WIDTH-1:0] dvd,
                         input logic [WIDTH-1:0] dvs, input logic [WIDTH-1:0] eq,
                         input logic [WIDTH-1:0] er, input logic edz, input int elat);
    strobe(dvd);
    chk({tag, "_done_drop"}, done, 1'b0);
    finish_div(tag, dvs, eq, er, edz, elat, -1);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    in_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_quotient", quotient, 8'd0);
    chk("rst_remainder", remainder, 8'd0);
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_dbz", div_by_zero, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    run_div("d100_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, WIDTH + 2);
    run_div("d255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, WIDTH + 2);

    // The old quotient stays visible after the next dividend is loaded.
    strobe(8'd5);
    chk("hold_q_after_load", quotient, 8'd255);
    chk("hold_done_drop", done, 1'b0);
    finish_div("d5_9", 8'd9, 8'd0, 8'd5, 1'b0, WIDTH + 2, -1);

    run_div("d255_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, WIDTH + 2);
    run_div("d37_0", 8'd37, 8'd0, 8'd255, 8'd37, 1'b0 | 1'b1, 2);

    // Reset during the fourth STEP cycle of 200/3.
    strobe(8'd200);
    strobe(8'd3);
    repeat (4) @(negedge clk);
    chk("mid_busy_before_rst", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_quotient", quotient, 8'd0);
    chk("mid_rst_remainder", remainder, 8'd0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_dbz", div_by_zero, 1'b0);
    repeat (3) @(negedge clk);
    chk("idle_stays_idle", busy, 1'b0);
    run_div("d200_3", 8'd200, 8'd3, 8'd66, 8'd2, 1'b0, WIDTH + 2);

    // Held start produces one strobe only. The changing bus value must not become the divisor.
    @(negedge clk);
    in_data = 8'd23;
    start   = 1'b1;
    @(negedge clk);
    in_data = 8'd99;
    repeat (4) @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("held_wait_busy", busy, 1'b1);
    chk("held_wait_done", done, 1'b0);
    finish_div("d23_5", 8'd5, 8'd4, 8'd3, 1'b0, WIDTH + 2, -1);

    // A start pulse during STEP has no effect.
    strobe(8'd77);
    finish_div("d77_6_pulse", 8'd6, 8'd12, 8'd5, 1'b0, WIDTH + 2, 4);
    repeat (2) @(negedge clk);
    chk("pulse_no_reload_done", done, 1'b1);

    // Back-to-back operations, each started as soon as the previous one is done.
    run_div("d50_4", 8'd50, 8'd4, 8'd12, 8'd2, 1'b0, WIDTH + 2);
    run_div("d9_10", 8'd9, 8'd10, 8'd0, 8'd9, 1'b0, WIDTH + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
